// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32 integer datapath.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xword_t;

   localparam reg_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: x0 forced to zero, stored-value
// mux and optional same-cycle forwarding of the write port.
module reg_read_port
   import rv_pkg::*;
#(
   parameter int XLEN_P = rv_pkg::XLEN,
   parameter int AW     = rv_pkg::REG_ADDR_W,
   parameter int BYPASS = 0
) (
   input  logic                            reset,
   input  logic [AW-1:0]                   addr,
   input  logic [(2**AW)-1:0][XLEN_P-1:0]  regs,
   input  logic                            we,
   input  logic [AW-1:0]                   wa,
   input  logic [XLEN_P-1:0]               wd,
   output logic [XLEN_P-1:0]               rd
);

   always_comb begin
      rd = '0;
      if (!reset && addr != '0) begin
         rd = regs[addr];
         // addr is non-zero here, so a match also excludes writes to x0
         if (BYPASS != 0 && we && wa == addr)
            rd = wd;
      end
   end

endmodule

// File: rtl/reg_file.sv
// 32-entry integer register file: two read ports for ALU operands, one
// synchronous write port, an unbypassed debug read port and a write counter.
module reg_file
   import rv_pkg::*;
#(
   parameter int XLEN      = rv_pkg::XLEN,
   parameter int NREG_LOG2 = rv_pkg::REG_ADDR_W,
   parameter int BYPASS    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREG_LOG2-1:0] A1,
   input  logic [NREG_LOG2-1:0] A2,
   input  logic [NREG_LOG2-1:0] A3,
   input  logic                 WE3,
   input  logic [XLEN-1:0]      WD3,
   output logic [XLEN-1:0]      RD1,
   output logic [XLEN-1:0]      RD2,
   input  logic [NREG_LOG2-1:0] dbg_addr,
   output logic [XLEN-1:0]      dbg_data,
   output logic [31:0]          wr_count
);

   localparam int NREG   = 2**NREG_LOG2;
   localparam int NPORTS = 2;

   logic [NREG-1:0][XLEN-1:0]        regs;
   logic [NPORTS-1:0][NREG_LOG2-1:0] raddr;
   logic [NPORTS-1:0][XLEN-1:0]      rdata;
   logic                             commit;

   assign commit = WE3 && (A3 != '0);

   // Entry 0 is cleared by reset and never written, so it stays zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs     <= '0;
         wr_count <= '0;
      end else if (commit) begin
         regs[A3] <= WD3;
         wr_count <= wr_count + 32'd1;
      end
   end

   assign raddr[0] = A1;
   assign raddr[1] = A2;

   for (genvar p = 0; p < NPORTS; p++) begin : g_rd
      reg_read_port #(
         .XLEN_P (XLEN),
         .AW     (NREG_LOG2),
         .BYPASS (BYPASS)
      ) u_port (
         .reset (reset),
         .addr  (raddr[p]),
         .regs  (regs),
         .we    (WE3),
         .wa    (A3),
         .wd    (WD3),
         .rd    (rdata[p])
      );
   end

   assign RD1      = rdata[0];
   assign RD2      = rdata[1];
   assign dbg_data = reset ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one instance per BYPASS setting on shared inputs.
module tb_reg_file;
   import rv_pkg::*;

   logic        clk = 0;
   logic        reset;
   logic [4:0]  A1, A2, A3, dbg_addr;
   logic        WE3;
   logic [31:0] WD3;
   logic [31:0] rd1_0, rd2_0, dbg_0, cnt_0;
   logic [31:0] rd1_1, rd2_1, dbg_1, cnt_1;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   reg_file #(.BYPASS(0)) dut0 (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
      .RD1(rd1_0), .RD2(rd2_0), .dbg_addr(dbg_addr), .dbg_data(dbg_0), .wr_count(cnt_0)
   );

   reg_file #(.BYPASS(1)) dut1 (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
      .RD1(rd1_1), .RD2(rd2_1), .dbg_addr(dbg_addr), .dbg_data(dbg_1), .wr_count(cnt_1)
   );

   // sig: 0..3 = dut0 rd1/rd2/dbg/cnt, 4..7 = dut1 same, 8 = ALU OR of dut0 operands
   function automatic logic [31:0] pick(int sig);
      case (sig)
         0: return rd1_0;
         1: return rd2_0;
         2: return dbg_0;
         3: return cnt_0;
         4: return rd1_1;
         5: return rd2_1;
         6: return dbg_1;
         7: return cnt_1;
         default: return rd1_0 | rd2_0;
      endcase
   endfunction

   // Outputs are combinational and settle within the cycle; compare mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() != 0) begin
            chk_t c;
            logic [31:0] act;
            c = q.pop_front();
            act = pick(c.sig);
            total++;
            if (act !== c.exp) begin
               bad++;
               $display("FAIL %s sig=%0d got=%h want=%h", c.name, c.sig, act, c.exp);
            end
         end
      end
   end

   task automatic expect_v(input string name, input int sig, input logic [31:0] exp);
      chk_t c;
      c.name = name; c.sig = sig; c.exp = exp;
      q.push_back(c);
   endtask

   task automatic expect_both(input string name, input int sig, input logic [31:0] exp);
      expect_v(name, sig, exp);
      expect_v(name, sig + 4, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      WE3 = 1; A3 = a; WD3 = d;
      step();
      WE3 = 0;
   endtask

   initial begin
      reset = 1; WE3 = 0; A1 = 0; A2 = 0; A3 = 0; WD3 = 0; dbg_addr = 0;
      step();
      A1 = 5; dbg_addr = 7;
      expect_both("rst_rd1", 0, 32'h0);
      expect_both("rst_dbg", 2, 32'h0);
      expect_both("rst_cnt", 3, 32'h0);
      step();
      reset = 0;

      // ALU operand path
      wr(5'd1, 32'hAAAAAAAA);
      wr(5'd2, 32'h55555555);
      A1 = 1; A2 = 2;
      expect_both("alu_rd1", 0, 32'hAAAAAAAA);
      expect_both("alu_rd2", 1, 32'h55555555);
      expect_both("alu_cnt", 3, 32'd2);
      expect_v("alu_or", 8, 32'hFFFFFFFF);
      step();

      // x0 protection, including no forwarding for A3=0
      WE3 = 1; A3 = REG_X0; WD3 = 32'hDEADBEEF; A1 = 0; A2 = 0; dbg_addr = 0;
      expect_both("x0_rd1_pre", 0, 32'h0);
      expect_both("x0_rd2_pre", 1, 32'h0);
      step();
      WE3 = 0;
      expect_both("x0_rd1", 0, 32'h0);
      expect_both("x0_dbg", 2, 32'h0);
      expect_both("x0_cnt", 3, 32'd2);
      step();

      // Bypass behaviour
      wr(5'd3, 32'h00000001);
      WE3 = 1; A3 = 3; WD3 = 32'h00000007; A1 = 3; A2 = 3; dbg_addr = 3;
      expect_v("byp0_rd1", 0, 32'h1);
      expect_v("byp0_rd2", 1, 32'h1);
      expect_v("byp1_rd1", 4, 32'h7);
      expect_v("byp1_rd2", 5, 32'h7);
      expect_both("byp_dbg", 2, 32'h1);
      step();
      WE3 = 0;
      expect_both("byp_post_rd1", 0, 32'h7);
      expect_both("byp_post_rd2", 1, 32'h7);
      expect_both("byp_post_dbg", 2, 32'h7);
      expect_both("byp_post_cnt", 3, 32'd4);
      step();

      // Mid-run reset and reset vs write
      wr(5'd5, 32'h12345678);
      A1 = 5; dbg_addr = 5;
      expect_both("pre_rst_rd1", 0, 32'h12345678);
      expect_both("pre_rst_cnt", 3, 32'd5);
      step();
      reset = 1; WE3 = 1; A3 = 4; WD3 = 32'hCAFEF00D; A2 = 4;
      expect_both("rst_now_rd1", 0, 32'h0);
      expect_both("rst_now_rd2", 1, 32'h0);
      expect_both("rst_now_dbg", 2, 32'h0);
      expect_both("rst_now_cnt", 3, 32'h0);
      step();
      reset = 0; WE3 = 0; A1 = 4; dbg_addr = 4;
      expect_both("rstwr_rd1", 0, 32'h0);
      expect_both("rstwr_dbg", 2, 32'h0);
      expect_both("rstwr_cnt", 3, 32'h0);
      step();

      // Full sweep
      for (int i = 1; i < 32; i++) wr(i[4:0], i * 32'h01010101);
      for (int i = 1; i < 32; i++) begin
         A1 = i[4:0]; A2 = i[4:0]; dbg_addr = i[4:0];
         expect_both("sweep_rd1", 0, i * 32'h01010101);
         expect_both("sweep_rd2", 1, i * 32'h01010101);
         expect_both("sweep_dbg", 2, i * 32'h01010101);
         step();
      end
      expect_both("sweep_cnt", 3, 32'd31);
      step();
      step();

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
